// File: rtl/pool_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_sequencer_pkg
//  Description : Shared pooling definitions: sequencer state encoding and
//                the pooling window size.
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_sequencer_pkg;

    // Side length of the square pooling window (2x2, stride 2)
    localparam int POOL_WIN = 2;

    // Sequencer states: even rows store raw elements, odd rows fold into them
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROW_EVEN = 2'd1,
        ST_ROW_ODD  = 2'd2,
        ST_FINISH   = 2'd3
    } pool_state_t;

endpackage : pool_sequencer_pkg
`default_nettype wire

// File: rtl/pool_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pool_sequencer
//  Description : Control sequencer for 2x2 / stride-2 pooling over a
//                register file fed by a systolic array. Generates reg-file
//                addresses, write enables, input mux select and window /
//                pass completion strobes.
//  Options     : POOL_SEQ_ABORT_EN - adds an 'abort' input that returns the
//                sequencer to IDLE mid-pass without a pool_finish pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_sequencer
    import pool_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = ADDR_W + 1,
    parameter int ROWS_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ROWS_W-1:0] cfg_rows,
`ifdef POOL_SEQ_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic [ADDR_W-1:0] adrs_in1,
    output logic [ADDR_W-1:0] adrs_in2,
    output logic [ADDR_W-1:0] adrs_out,
    output logic              wr_ctrl1,
    output logic              wr_ctrl2,
    output logic              mux_en,
    output logic              pool_done,
    output logic              pool_finish,
    output logic              busy
);

    localparam logic [LEN_W-1:0]  LEN_MIN  = LEN_W'(POOL_WIN);
    localparam logic [ROWS_W-1:0] ROWS_MIN = ROWS_W'(POOL_WIN);

    pool_state_t        state;
    pool_state_t        state_nxt;
    logic [LEN_W-1:0]   len;
    logic [ROWS_W-1:0]  rows;
    logic [LEN_W-1:0]   e;
    logic [ROWS_W-1:0]  r;
    logic [ADDR_W-1:0]  adr;
    logic [LEN_W-1:0]   len_even;
    logic [ROWS_W-1:0]  rows_even;
    logic [LEN_W-1:0]   len_sel;
    logic [ROWS_W-1:0]  rows_sel;
    logic               e_last;
    logic               row_last;

    // Round configuration down to whole windows, with at least one window
    always_comb begin
        len_even  = cfg_len & ~LEN_W'(1);
        rows_even = cfg_rows & ~ROWS_W'(1);
        len_sel   = (len_even < LEN_MIN) ? LEN_MIN : len_even;
        rows_sel  = (rows_even < ROWS_MIN) ? ROWS_MIN : rows_even;
        e_last    = (e == len - LEN_W'(1));
        row_last  = (r == rows - ROWS_MIN);
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Mealy outputs; strobes only fire alongside valid data
    always_comb begin
        state_nxt   = state;
        adr         = '0;
        wr_ctrl1    = 1'b0;
        wr_ctrl2    = 1'b0;
        mux_en      = 1'b0;
        pool_done   = 1'b0;
        pool_finish = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_ROW_EVEN;
                end
            end
            ST_ROW_EVEN: begin
                adr = ADDR_W'(e >> 1);
                if (in_valid) begin
                    mux_en   = 1'b1;
                    wr_ctrl1 = ~e[0];
                    wr_ctrl2 = e[0];
                    if (e_last) begin
                        state_nxt = ST_ROW_ODD;
                    end
                end
            end
            ST_ROW_ODD: begin
                adr = ADDR_W'(e >> 1);
                if (in_valid) begin
                    mux_en    = 1'b1;
                    wr_ctrl2  = 1'b1;
                    pool_done = e[0];
                    if (e_last) begin
                        state_nxt = row_last ? ST_FINISH : ST_ROW_EVEN;
                    end
                end
            end
            ST_FINISH: begin
                pool_finish = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef POOL_SEQ_ABORT_EN
        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
`endif
    end

    // Element / row counters and pass configuration latched at start
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            len  <= LEN_MIN;
            rows <= ROWS_MIN;
            e    <= '0;
            r    <= '0;
        end else
`ifdef POOL_SEQ_ABORT_EN
        if (abort && (state != ST_IDLE)) begin
            e <= '0;
            r <= '0;
        end else
`endif
        begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len  <= len_sel;
                        rows <= rows_sel;
                        e    <= '0;
                        r    <= '0;
                    end
                end
                ST_ROW_EVEN: begin
                    if (in_valid) begin
                        e <= e_last ? '0 : e + LEN_W'(1);
                    end
                end
                ST_ROW_ODD: begin
                    if (in_valid) begin
                        if (e_last) begin
                            e <= '0;
                            r <= r + ROWS_MIN;
                        end else begin
                            e <= e + LEN_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One address drives both write ports and the read port
    assign adrs_in1 = adr;
    assign adrs_in2 = adr;
    assign adrs_out = adr;

endmodule : pool_sequencer
`default_nettype wire

// File: tb/tb_pool_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_sequencer
//  Description : Directed self-checking bench for pool_sequencer. Honours
//                POOL_SEQ_ABORT_EN to exercise the abort input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_sequencer;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int ROWS_W = 8;
    localparam int VEC_W  = 6 + 3 * ADDR_W;

    // Expected strobe groups for a cycle
    localparam int K_NONE = 0;  // no strobes
    localparam int K_W1   = 1;  // wr_ctrl1 + mux_en
    localparam int K_W2   = 2;  // wr_ctrl2 + mux_en
    localparam int K_WD   = 3;  // wr_ctrl2 + mux_en + pool_done

    logic              clk;
    logic              nrst;
    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [ROWS_W-1:0] cfg_rows;
    logic              in_valid;
    logic [ADDR_W-1:0] adrs_in1;
    logic [ADDR_W-1:0] adrs_in2;
    logic [ADDR_W-1:0] adrs_out;
    logic              wr_ctrl1;
    logic              wr_ctrl2;
    logic              mux_en;
    logic              pool_done;
    logic              pool_finish;
    logic              busy;
`ifdef POOL_SEQ_ABORT_EN
    logic              abort;
`endif

    int n_cmp;
    int n_bad;

    pool_sequencer #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .ROWS_W (ROWS_W)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_rows    (cfg_rows),
`ifdef POOL_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .in_valid    (in_valid),
        .adrs_in1    (adrs_in1),
        .adrs_in2    (adrs_in2),
        .adrs_out    (adrs_out),
        .wr_ctrl1    (wr_ctrl1),
        .wr_ctrl2    (wr_ctrl2),
        .mux_en      (mux_en),
        .pool_done   (pool_done),
        .pool_finish (pool_finish),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all outputs at once against the expected picture
    task automatic check(input string tag, input int b, input int fin,
                         input int kind, input int adr);
        logic [VEC_W-1:0]  obs;
        logic [VEC_W-1:0]  exp_v;
        logic [ADDR_W-1:0] a;
        logic              w1, w2, mx, dn;
        a  = ADDR_W'(adr);
        w1 = (kind == K_W1);
        w2 = (kind == K_W2) || (kind == K_WD);
        mx = (kind != K_NONE);
        dn = (kind == K_WD);
        exp_v = {b[0], fin[0], dn, mx, w2, w1, a, a, a};
        obs   = {busy, pool_finish, pool_done, mux_en, wr_ctrl2, wr_ctrl1,
                 adrs_in1, adrs_in2, adrs_out};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (busy,fin,done,mux,wr2,wr1,a1,a2,ao)",
                   tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check before the rising edge
    task automatic cyc(input string tag, input logic s, input logic v,
                       input int b, input int fin, input int kind, input int adr);
        @(negedge clk);
        start    = s;
        in_valid = v;
        #4;
        check(tag, b, fin, kind, adr);
    endtask

    // Full pass: rows_n rows of len_n elements; optional gaps and stray starts
    task automatic pass(input string tag, input int len_n, input int rows_n,
                        input bit gapped, input int start_at, input bit start_fin);
        int idx;
        int kind;
        idx = 0;
        cyc({tag, "/start"}, 1'b1, 1'b0, 0, 0, K_NONE, 0);
        for (int row = 0; row < rows_n; row++) begin
            for (int el = 0; el < len_n; el++) begin
                if (row % 2 == 0) kind = (el % 2 == 0) ? K_W1 : K_W2;
                else              kind = (el % 2 == 0) ? K_W2 : K_WD;
                if (gapped) begin
                    cyc({tag, "/gap"}, 1'b0, 1'b0, 1, 0, K_NONE, el / 2);
                end
                cyc({tag, "/elem"}, (idx == start_at), 1'b1, 1, 0, kind, el / 2);
                idx++;
            end
        end
        cyc({tag, "/finish"}, start_fin, 1'b1, 1, 1, K_NONE, 0);
        cyc({tag, "/idle"}, 1'b0, 1'b1, 0, 0, K_NONE, 0);
        cyc({tag, "/idle2"}, 1'b0, 1'b0, 0, 0, K_NONE, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        nrst     = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        cfg_len  = LEN_W'(4);
        cfg_rows = ROWS_W'(2);
`ifdef POOL_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        // Reset state, including with valid asserted
        #12;
        check("reset", 0, 0, K_NONE, 0);
        in_valid = 1'b1;
        #1;
        check("reset_valid", 0, 0, K_NONE, 0);
        @(negedge clk);
        nrst = 1'b1;
        cyc("idle_no_start", 1'b0, 1'b1, 0, 0, K_NONE, 0);

        // 4x2 contiguous: wr1 at 0,2; done at 5,7; finish after 7
        pass("len4_rows2", 4, 2, 1'b0, -1, 1'b0);

        // Same with gaps every other cycle
        pass("gapped", 4, 2, 1'b1, -1, 1'b0);

        // Odd configuration rounds down to 4x2
        cfg_len  = LEN_W'(5);
        cfg_rows = ROWS_W'(3);
        pass("len5_rows3", 4, 2, 1'b0, -1, 1'b0);

        // Zero length and single row round up to one window
        cfg_len  = LEN_W'(0);
        cfg_rows = ROWS_W'(1);
        pass("len0_rows1", 2, 2, 1'b0, -1, 1'b0);

        // Multi-row pass exercises the row counter
        cfg_len  = LEN_W'(2);
        cfg_rows = ROWS_W'(4);
        pass("len2_rows4", 2, 4, 1'b0, -1, 1'b0);

        // Stray starts mid-pass and in FINISH; config change must not be latched
        cfg_len  = LEN_W'(4);
        cfg_rows = ROWS_W'(2);
        fork
            begin
                repeat (3) @(negedge clk);
                #1;
                cfg_len  = LEN_W'(8);
                cfg_rows = ROWS_W'(6);
            end
        join_none
        pass("start_ignored", 4, 2, 1'b0, 3, 1'b1);

        // Reset after 3 elements: outputs drop at once, no finish follows
        cfg_len  = LEN_W'(4);
        cfg_rows = ROWS_W'(2);
        cyc("rst/start", 1'b1, 1'b0, 0, 0, K_NONE, 0);
        cyc("rst/e0", 1'b0, 1'b1, 1, 0, K_W1, 0);
        cyc("rst/e1", 1'b0, 1'b1, 1, 0, K_W2, 0);
        cyc("rst/e2", 1'b0, 1'b1, 1, 0, K_W1, 1);
        @(negedge clk);
        in_valid = 1'b1;
        check("rst/pre", 1, 0, K_W2, 1);
        nrst = 1'b0;
        #1;
        check("rst/asserted", 0, 0, K_NONE, 0);
        @(negedge clk);
        nrst = 1'b1;
        cyc("rst/after1", 1'b0, 1'b1, 0, 0, K_NONE, 0);
        cyc("rst/after2", 1'b0, 1'b1, 0, 0, K_NONE, 0);
        pass("rst/rerun", 4, 2, 1'b0, -1, 1'b0);

`ifdef POOL_SEQ_ABORT_EN
        // Abort after 6 of 16 elements of a 4x4 pass
        cfg_len  = LEN_W'(4);
        cfg_rows = ROWS_W'(4);
        cyc("abort/start", 1'b1, 1'b0, 0, 0, K_NONE, 0);
        cyc("abort/e0", 1'b0, 1'b1, 1, 0, K_W1, 0);
        cyc("abort/e1", 1'b0, 1'b1, 1, 0, K_W2, 0);
        cyc("abort/e2", 1'b0, 1'b1, 1, 0, K_W1, 1);
        cyc("abort/e3", 1'b0, 1'b1, 1, 0, K_W2, 1);
        cyc("abort/e4", 1'b0, 1'b1, 1, 0, K_W2, 0);
        cyc("abort/e5", 1'b0, 1'b1, 1, 0, K_WD, 0);
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b0;
        #4;
        check("abort/cycle", 1, 0, K_NONE, 1);
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc("abort/after", 1'b0, 1'b1, 0, 0, K_NONE, 0);
        end
        pass("abort/rerun", 4, 4, 1'b0, -1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pool_sequencer
`default_nettype wire
